// File: rtl/fft_result_unloader_if.sv
// Result stream from fft_result_unloader to its consumer.
interface fft_result_unloader_if;
  // A transfer happens on a rising edge where out_valid and out_ready are both high;
  // while out_valid is high and out_ready is low, out_data/out_index hold stable.
  logic [31:0] out_data;
  logic [12:0] out_index;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_index, output out_valid, input out_ready);
  modport slave  (input out_data, input out_index, input out_valid, output out_ready);
endinterface

// File: rtl/fft_result_unloader.sv
// Walks the FFT2D result BRAMs through port A and streams each element out sign-extended.
// Optional running checksum of transferred samples is enabled with `define UNLOAD_CHECKSUM_EN.
module fft_result_unloader #(
  parameter int NBRAM     = 32,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 256,
  parameter int ROWS      = 2,
  parameter int ELEMS     = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic [NBRAM*DATA_W-1:0]   FFT_dataa,
  output logic [NBRAM*ADDR_W-1:0]   FFT_addra,
  output logic [NBRAM-1:0]          FFT_wea,
  output logic [NBRAM-1:0]          FFT_rea,
  fft_result_unloader_if.master     stream,
  output logic [31:0]               checksum,
  output logic [2:0]                state
);

  localparam int I_W = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int J_W = (NBRAM > 1) ? $clog2(NBRAM) : 1;
  localparam int K_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [I_W-1:0]    i_q;
  logic [J_W-1:0]    j_q;
  logic [K_W-1:0]    k_q;
  logic [31:0]       data_q;
  logic [12:0]       index_q;
  logic              start_ok;
  logic              accept;
  logic              last_elem;
  logic              i_last, j_last, k_last;
  logic [ADDR_W-1:0] addr_cur;
  logic [12:0]       index_cur;
  logic [DATA_W-1:0] rd_slice;

  assign start_ok  = (state_q == S_IDLE) && start;
  assign accept    = (state_q == S_OUTPUT) && stream.out_ready;
  assign i_last    = (i_q == I_W'(ROWS - 1));
  assign j_last    = (j_q == J_W'(NBRAM - 1));
  assign k_last    = (k_q == K_W'(ELEMS - 1));
  assign last_elem = i_last && j_last && k_last;

  assign addr_cur  = ADDR_W'(BASE_ADDR) + ADDR_W'(i_q) * ADDR_W'(ELEMS) + ADDR_W'(k_q);
  assign index_cur = 13'(i_q) * 13'(NBRAM * ELEMS) + 13'(j_q) * 13'(ELEMS) + 13'(k_q);
  assign rd_slice  = FFT_dataa[int'(j_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUTPUT;
      S_OUTPUT:  if (stream.out_ready) state_d = last_elem ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Scan counters: k innermost, then BRAM j, then row i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (start_ok) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (accept && !last_elem) begin
      if (k_last) begin
        k_q <= '0;
        if (j_last) begin
          j_q <= '0;
          i_q <= i_q + I_W'(1);
        end else begin
          j_q <= j_q + J_W'(1);
        end
      end else begin
        k_q <= k_q + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      index_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      data_q  <= {{(32-DATA_W){rd_slice[DATA_W-1]}}, rd_slice};
      index_q <= index_cur;
    end
  end

  // The address stays on the active slice through OUTPUT so it is stable under backpressure.
  always_comb begin
    FFT_addra = '0;
    FFT_rea   = '0;
    if (state_q == S_ISSUE || state_q == S_CAPTURE || state_q == S_OUTPUT)
      FFT_addra[int'(j_q)*ADDR_W +: ADDR_W] = addr_cur;
    if (state_q == S_ISSUE || state_q == S_CAPTURE)
      FFT_rea[j_q] = 1'b1;
  end

  assign FFT_wea          = '0;
  assign busy             = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_OUTPUT);
  assign done             = (state_q == S_DONE);
  assign stream.out_valid = (state_q == S_OUTPUT);
  assign stream.out_data  = data_q;
  assign stream.out_index = index_q;
  assign state            = state_q;

`ifdef UNLOAD_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sum_q <= '0;
    else if (start_ok) sum_q <= '0;
    else if (accept)   sum_q <= sum_q + data_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
